// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - two-requester burst arbiter in front of a shared SPI byte engine
// Optional owner-stall timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arb #(
  parameter int CS_SETUP       = 2,
  parameter int CS_HOLD        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [1:0]      req_valid_i,
  input  logic [1:0][7:0] req_data_i,
  input  logic [1:0]      req_last_i,
  output logic [1:0]      req_ready_o,
  output logic [1:0]      rsp_valid_o,
  output logic [7:0]      rsp_data_o,
  output logic            eng_start_o,
  output logic [7:0]      eng_txbyte_o,
  input  logic            eng_busy_i,
  input  logic            eng_done_i,
  input  logic [7:0]      eng_rxbyte_i,
  output logic [1:0]      spi_ss_o,
  output logic            err_o
);

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, HOLD} state_t;

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       last_grant;
  logic       last_flag;
  logic [3:0] phase_cnt;
  logic       accept;
  logic       timeout;

  // Round robin only matters on contention; a lone requester always wins.
  assign owner_nxt = (req_valid_i == 2'b11) ? ~last_grant : req_valid_i[1];
  assign accept    = (state == ISSUE) && req_valid_i[owner] && !eng_busy_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (|req_valid_i) state_nxt = SETUP;
      SETUP: if (phase_cnt == 4'(CS_SETUP - 1)) state_nxt = ISSUE;
      ISSUE: begin
        if (accept)       state_nxt = WAIT;
        else if (timeout) state_nxt = HOLD;
      end
      WAIT:  if (eng_done_i) state_nxt = last_flag ? HOLD : ISSUE;
      HOLD:  if (phase_cnt == 4'(CS_HOLD - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o        = 2'b00;
    req_ready_o[owner] = accept;
    eng_start_o        = accept;
    eng_txbyte_o       = accept ? req_data_i[owner] : 8'h00;
    spi_ss_o           = 2'b11;
    if (state != IDLE) spi_ss_o[owner] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      last_flag   <= 1'b0;
      phase_cnt   <= 4'd0;
      rsp_valid_o <= 2'b00;
      rsp_data_o  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        phase_cnt <= 4'd0;
      else if (state == SETUP || state == HOLD)
        phase_cnt <= phase_cnt + 4'd1;
      if (state == IDLE && |req_valid_i) owner <= owner_nxt;
      if (accept) last_flag <= req_last_i[owner];
      if (state == HOLD && state_nxt == IDLE) last_grant <= owner;
      // Done pulses outside WAIT belong to no burst and are dropped.
      rsp_valid_o <= 2'b00;
      if (state == WAIT && eng_done_i) begin
        rsp_valid_o[owner] <= 1'b1;
        rsp_data_o         <= eng_rxbyte_i;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;

  assign timeout = (state == ISSUE) && !req_valid_i[owner] &&
                   (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      stall_cnt <= 16'd0;
      err_o     <= 1'b0;
    end else begin
      err_o <= timeout;
      if (state != ISSUE || accept)
        stall_cnt <= 16'd0;
      else if (!req_valid_i[owner])
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arb.sv
// tb/tb_spi_arb.sv - directed self-checking bench for spi_arb with an 8-cycle engine model
// Timeout expectations follow SPI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16.
module tb_spi_arb;

  logic            clk = 1'b0;
  logic            rstn;
  logic [1:0]      req_valid;
  logic [1:0][7:0] req_data;
  logic [1:0]      req_last;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [7:0]      rsp_data;
  logic            eng_start;
  logic [7:0]      eng_txbyte;
  logic            eng_busy;
  logic            eng_done;
  logic [7:0]      eng_rxbyte;
  logic [1:0]      spi_ss;
  logic            err;

  int errors = 0;
  int checks = 0;

  spi_arb #(.CS_SETUP(2), .CS_HOLD(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .eng_start_o(eng_start), .eng_txbyte_o(eng_txbyte),
    .eng_busy_i(eng_busy), .eng_done_i(eng_done), .eng_rxbyte_i(eng_rxbyte),
    .spi_ss_o(spi_ss), .err_o(err)
  );

  always #5 clk = ~clk;

  // Engine: done lands 8 cycles after the start cycle; RX is ~TX unless forced.
  logic [7:0] rx_force;
  logic       rx_force_en;
  initial begin
    int left;
    logic st;
    logic [7:0] tx, pend_tx;
    eng_busy = 1'b0; eng_done = 1'b0; eng_rxbyte = 8'h00;
    left = 0; pend_tx = 8'h00;
    forever begin
      @(negedge clk);
      st = eng_start; tx = eng_txbyte;
      @(posedge clk); #1;
      eng_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          eng_done = 1'b1; eng_busy = 1'b0;
          eng_rxbyte = rx_force_en ? rx_force : ~pend_tx;
        end
      end
      if (st) begin left = 7; eng_busy = 1'b1; pend_tx = tx; end
    end
  end

  int cyc = 0, starts = 0, bad_start = 0, bad_ready = 0, bad_ss = 0, errs = 0;
  int rsp_cnt[2] = '{0, 0};
  logic [7:0] rsp_last[2];
  logic [7:0] last_tx;
  int done_cyc = 0, rsp_cyc = 0;
  int run = 0, gap = 0, min_gap = 1000, cur_owner = 0;
  int run_len[2] = '{0, 0};
  int grants[$];
  logic [1:0] prev_ss = 2'b11;

  always @(negedge clk) begin
    cyc++;
    if (eng_start) begin
      starts++; last_tx = eng_txbyte;
      if (eng_busy) bad_start++;
    end
    if (eng_done) done_cyc = cyc;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i]) begin rsp_cnt[i]++; rsp_last[i] = rsp_data; rsp_cyc = cyc; end
      if (req_ready[i] && spi_ss[i]) bad_ready++;
    end
    if (spi_ss == 2'b00 || rsp_valid == 2'b11) bad_ss++;
    if (err) errs++;
    if (spi_ss == 2'b11) begin
      if (prev_ss != 2'b11) run_len[cur_owner] = run;
      gap++;
    end else begin
      if (prev_ss == 2'b11) begin
        cur_owner = (spi_ss == 2'b10) ? 0 : 1;
        grants.push_back(cur_owner);
        if (gap < min_gap) min_gap = gap;
        run = 0; gap = 0;
      end
      run++;
    end
    prev_ss = spi_ss;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_accept(input int r);
    int t = 0;
    logic got = 1'b0;
    while (!got && t < 500) begin
      @(negedge clk); got = req_ready[r];
      @(posedge clk); #1; t++;
    end
    if (!got) check($sformatf("accept_timeout_r%0d", r), 0, 1);
  endtask

  task automatic send_burst(input int r, input int n, input logic [7:0] b0,
                            input int stall_k, input int stall_n);
    for (int k = 0; k < n; k++) begin
      req_valid[r] = 1'b1; req_data[r] = b0 + 8'(k); req_last[r] = (k == n - 1);
      wait_accept(r);
      req_valid[r] = 1'b0; req_last[r] = 1'b0;
      if (k == stall_k) begin repeat (stall_n) @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (spi_ss != 2'b11 && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) check("idle_timeout", 0, 1);
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    int r0, r1, s0, e0;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1, s0, e0;
    rstn = 1'b0; req_valid = 2'b00; req_data = '0; req_last = 2'b00;
    rx_force = 8'h00; rx_force_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ss", spi_ss, 2'b11);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_start", eng_start, 0);
    check("rst_txbyte", eng_txbyte, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1; rstn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Contention twice after reset: grants 0,1,0,1 with one SS-high cycle between.
    for (int round = 0; round < 2; round++) begin
      fork
        send_burst(0, 1, 8'h10, -1, 0);
        send_burst(1, 1, 8'h20, -1, 0);
      join
      wait_idle();
    end
    check("rr_count", grants.size(), 4);
    if (grants.size() == 4) begin
      check("rr_g0", grants[0], 0);
      check("rr_g1", grants[1], 1);
      check("rr_g2", grants[2], 0);
      check("rr_g3", grants[3], 1);
    end
    check("rr_min_gap", min_gap, 1);
    check("rr_rsp0", rsp_cnt[0], 2);
    check("rr_rsp1", rsp_cnt[1], 2);
    check("rr_rsp1_data", rsp_last[1], 8'hDF);
    grants.delete();

    // Single-byte burst 0xA5 returning 0x3C.
    rx_force = 8'h3C; rx_force_en = 1'b1;
    r0 = rsp_cnt[0]; r1 = rsp_cnt[1];
    send_burst(0, 1, 8'hA5, -1, 0);
    check("single_tx", last_tx, 8'hA5);
    wait_idle();
    rx_force_en = 1'b0;
    check("single_ss_len", run_len[0], 13);
    check("single_rsp0", rsp_cnt[0] - r0, 1);
    check("single_rsp1", rsp_cnt[1] - r1, 0);
    check("single_rsp_data", rsp_last[0], 8'h3C);
    check("single_rsp_lat", rsp_cyc - done_cyc, 1);
    check("single_hold_data", rsp_data, 8'h3C);

    // req1 3-byte burst while req0 waits; req0 follows.
    r0 = rsp_cnt[0]; r1 = rsp_cnt[1];
    fork
      send_burst(1, 3, 8'h50, -1, 0);
      send_burst(0, 1, 8'h77, -1, 0);
    join
    wait_idle();
    check("lock_count", grants.size(), 3);
    if (grants.size() == 3) begin
      check("lock_g1", grants[1], 1);
      check("lock_g2", grants[2], 0);
    end
    check("lock_ss_len", run_len[1], 31);
    check("lock_rsp1", rsp_cnt[1] - r1, 3);
    check("lock_rsp0", rsp_cnt[0] - r0, 1);
    check("lock_rsp1_data", rsp_last[1], 8'hAD);
    grants.delete();

    // Owner stall of 10 ISSUE cycles between byte 0 and byte 1.
    s0 = starts;
    send_burst(0, 3, 8'h30, 0, 18);
    wait_idle();
    check("stall_ss_len", run_len[0], 41);
    check("stall_starts", starts - s0, 3);
    check("stall_last_tx", last_tx, 8'h32);
    check("stall_err", errs, 0);

    // Owner stalls 16+ cycles after a non-last byte.
    e0 = errs;
    req_valid[0] = 1'b1; req_data[0] = 8'h40; req_last[0] = 1'b0;
    wait_accept(0);
    req_valid[0] = 1'b0;
    repeat (30) @(posedge clk); #1;
`ifdef SPI_ARB_TIMEOUT_EN
    check("to_err_pulses", errs - e0, 1);
    check("to_ss_idle", spi_ss, 2'b11);
    check("to_ss_len", run_len[0], 29);
`else
    check("to_err_pulses", errs - e0, 0);
    check("to_ss_low", spi_ss, 2'b10);
    send_burst(0, 1, 8'h41, -1, 0);
    wait_idle();
    check("to_err_after", errs - e0, 0);
`endif

    // Reset during WAIT: SS high at once, no response, req0 wins next contention.
    r0 = rsp_cnt[0];
    req_valid[0] = 1'b1; req_data[0] = 8'h66; req_last[0] = 1'b1;
    wait_accept(0);
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    repeat (2) @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rstmid_ss", spi_ss, 2'b11);
    check("rstmid_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1; rstn = 1'b1;
    repeat (12) @(posedge clk); #1;
    check("rstmid_no_rsp", rsp_cnt[0] - r0, 0);
    grants.delete();
    fork
      send_burst(0, 1, 8'h01, -1, 0);
      send_burst(1, 1, 8'h02, -1, 0);
    join
    wait_idle();
    check("rstmid_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check("rstmid_g0", grants[0], 0);
      check("rstmid_g1", grants[1], 1);
    end

    check("start_while_busy", bad_start, 0);
    check("ready_non_owner", bad_ready, 0);
    check("ss_or_rsp_both", bad_ss, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
